// File: rtl/run_controller.sv
// Sequences a controlled component through reset / go phases for a number of runs,
// measuring per-run cycle counts with an optional per-run cycle limit.
module run_controller #(
  parameter int RESET_CYCLES = 3,
  parameter int CW           = 64,
  parameter int RW           = 8,
  parameter int REARM_RESET  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RW-1:0] num_runs,
  input  logic [CW-1:0] cycle_limit,
  input  logic          dut_done,
  output logic          dut_reset,
  output logic          dut_go,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] last_cycles,
  output logic [CW-1:0] total_cycles,
  output logic [RW-1:0] runs_done,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_END  = 3'd4
  } state_t;

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t         state_q;
  logic [RCW-1:0] rst_cnt_q;
  logic [CW-1:0]  run_cnt_q;
  logic [CW-1:0]  lim_q;
  logic [RW-1:0]  n_q;
  logic [CW-1:0]  last_q;
  logic [CW-1:0]  total_q;
  logic [RW-1:0]  runs_q;
  logic           dut_reset_q;
  logic           dut_go_q;
  logic           busy_q;
  logic           finished_q;
  logic           timeout_q;

  logic [CW-1:0]  run_d;
  logic [CW:0]    sum_d;
  logic [CW-1:0]  total_d;
  logic           last_run_d;

  // run_cnt_q holds completed RUN cycles; run_d is the count including this cycle.
  always_comb begin
    run_d      = (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + CW'(1);
    sum_d      = {1'b0, total_q} + {1'b0, run_d};
    total_d    = sum_d[CW] ? CNT_MAX : sum_d[CW-1:0];
    last_run_d = ((runs_q + RW'(1)) == n_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      run_cnt_q   <= '0;
      lim_q       <= '0;
      n_q         <= '0;
      last_q      <= '0;
      total_q     <= '0;
      runs_q      <= '0;
      dut_reset_q <= 1'b0;
      dut_go_q    <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      finished_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            timeout_q   <= 1'b0;
            total_q     <= '0;
            runs_q      <= '0;
            n_q         <= (num_runs == '0) ? RW'(1) : num_runs;
            lim_q       <= cycle_limit;
            rst_cnt_q   <= '0;
            dut_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_RST;
          end
        end
        S_RST: begin
          if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) begin
            dut_reset_q <= 1'b0;
            dut_go_q    <= 1'b1;
            run_cnt_q   <= '0;
            state_q     <= S_RUN;
          end else begin
            rst_cnt_q <= rst_cnt_q + RCW'(1);
          end
        end
        S_RUN: begin
          run_cnt_q <= run_d;
          // Done wins over a limit reached in the same cycle.
          if (dut_done) begin
            last_q   <= run_d;
            total_q  <= total_d;
            runs_q   <= runs_q + RW'(1);
            dut_go_q <= 1'b0;
            state_q  <= last_run_d ? S_END : S_GAP;
          end else if (lim_q != '0 && run_d == lim_q) begin
            timeout_q <= 1'b1;
            last_q    <= lim_q;
            dut_go_q  <= 1'b0;
            state_q   <= S_END;
          end
        end
        S_GAP: begin
          if (REARM_RESET != 0) begin
            rst_cnt_q   <= '0;
            dut_reset_q <= 1'b1;
            state_q     <= S_RST;
          end else begin
            run_cnt_q <= '0;
            dut_go_q  <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_END: begin
          busy_q     <= 1'b0;
          finished_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          dut_reset_q <= 1'b0;
          dut_go_q    <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign dut_reset    = dut_reset_q;
  assign dut_go       = dut_go_q;
  assign busy         = busy_q;
  assign finished     = finished_q;
  assign timeout      = timeout_q;
  assign last_cycles  = last_q;
  assign total_cycles = total_q;
  assign runs_done    = runs_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Drives three run_controller configurations (default, re-arming reset, narrow counters)
// with shared sequence requests; a reactive responder plays the controlled component.
module tb_run_controller;

  localparam int RC_K[3]    = '{3, 2, 1};
  localparam int REARM_K[3] = '{0, 1, 0};
  localparam int CW_K[3]    = '{64, 64, 4};

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  num_runs;
  logic [63:0] cycle_limit;

  logic [2:0]  done_v, rst_v, go_v, busy_v, fin_v, to_v;
  logic [63:0] last_a, total_a, last_b, total_b;
  logic [3:0]  last_c, total_c;
  logic [7:0]  runs_a, runs_b, runs_c;
  logic [2:0]  dbg_a, dbg_b, dbg_c;

  int n_checks = 0;
  int n_fails  = 0;

  int unsigned dly[$];
  longint unsigned exp_last[3];

  // responder and monitor state
  int rcnt[3], ridx[3];
  int go_cnt[3], rst_cyc[3], rst_ph[3], rst_bad[3], rst_len[3];
  int fin_cnt[3], ovl_cnt[3], gaps[3], gap_bad[3], low_len[3];
  bit seen_go[3], go_prev[3], rst_prev[3];

  run_controller #(.RESET_CYCLES(3), .CW(64), .RW(8), .REARM_RESET(0)) u_a (
    .clk(clk), .reset(reset), .start(start), .num_runs(num_runs), .cycle_limit(cycle_limit),
    .dut_done(done_v[0]), .dut_reset(rst_v[0]), .dut_go(go_v[0]), .busy(busy_v[0]),
    .finished(fin_v[0]), .timeout(to_v[0]), .last_cycles(last_a), .total_cycles(total_a),
    .runs_done(runs_a), .dbg_state(dbg_a));

  run_controller #(.RESET_CYCLES(2), .CW(64), .RW(8), .REARM_RESET(1)) u_b (
    .clk(clk), .reset(reset), .start(start), .num_runs(num_runs), .cycle_limit(cycle_limit),
    .dut_done(done_v[1]), .dut_reset(rst_v[1]), .dut_go(go_v[1]), .busy(busy_v[1]),
    .finished(fin_v[1]), .timeout(to_v[1]), .last_cycles(last_b), .total_cycles(total_b),
    .runs_done(runs_b), .dbg_state(dbg_b));

  run_controller #(.RESET_CYCLES(1), .CW(4), .RW(8), .REARM_RESET(0)) u_c (
    .clk(clk), .reset(reset), .start(start), .num_runs(num_runs), .cycle_limit(cycle_limit[3:0]),
    .dut_done(done_v[2]), .dut_reset(rst_v[2]), .dut_go(go_v[2]), .busy(busy_v[2]),
    .finished(fin_v[2]), .timeout(to_v[2]), .last_cycles(last_c), .total_cycles(total_c),
    .runs_done(runs_c), .dbg_state(dbg_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint unsigned get_last(input int k);
    case (k)
      0:       return last_a;
      1:       return last_b;
      default: return {60'd0, last_c};
    endcase
  endfunction

  function automatic longint unsigned get_total(input int k);
    case (k)
      0:       return total_a;
      1:       return total_b;
      default: return {60'd0, total_c};
    endcase
  endfunction

  function automatic longint unsigned get_runs(input int k);
    case (k)
      0:       return runs_a;
      1:       return runs_b;
      default: return runs_c;
    endcase
  endfunction

  // Controlled component: raises done in the dly[i]-th go cycle of run i (0 = never).
  // While go is low it toggles done randomly; the controller must ignore that.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (go_v[k]) begin
        rcnt[k] = rcnt[k] + 1;
        if (ridx[k] < dly.size() && dly[ridx[k]] == rcnt[k]) begin
          done_v[k] = 1'b1;
          ridx[k] = ridx[k] + 1;
        end else begin
          done_v[k] = 1'b0;
        end
      end else begin
        rcnt[k] = 0;
        done_v[k] = ($urandom_range(0, 3) == 0);
        if (!busy_v[k]) ridx[k] = 0;
      end
    end
  end

  // Observes output waveforms: reset phase lengths, go gaps, finished pulses.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (go_v[k]) go_cnt[k] = go_cnt[k] + 1;
      if (go_v[k] && rst_v[k]) ovl_cnt[k] = ovl_cnt[k] + 1;
      if (fin_v[k]) fin_cnt[k] = fin_cnt[k] + 1;
      if (rst_v[k]) begin
        rst_cyc[k] = rst_cyc[k] + 1;
        if (!rst_prev[k]) begin
          rst_ph[k] = rst_ph[k] + 1;
          rst_len[k] = 1;
        end else begin
          rst_len[k] = rst_len[k] + 1;
        end
      end else if (rst_prev[k]) begin
        if (rst_len[k] != RC_K[k]) rst_bad[k] = rst_bad[k] + 1;
      end
      if (!busy_v[k]) begin
        seen_go[k] = 1'b0;
        low_len[k] = 0;
      end else if (go_v[k]) begin
        if (!go_prev[k] && seen_go[k]) begin
          gaps[k] = gaps[k] + 1;
          if (low_len[k] != (REARM_K[k] != 0 ? 1 + RC_K[k] : 1)) gap_bad[k] = gap_bad[k] + 1;
        end
        seen_go[k] = 1'b1;
        low_len[k] = 0;
      end else begin
        low_len[k] = low_len[k] + 1;
      end
      go_prev[k] = go_v[k];
      rst_prev[k] = rst_v[k];
    end
  end

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: outcome of a sequence from the run/limit rules alone.
  function automatic void predict(input int k, input int n_in, input longint unsigned lim_in,
                                  inout longint unsigned last, output longint unsigned total,
                                  output int runs, output int starts, output int go_cyc,
                                  output bit to);
    longint unsigned cap, lim, d;
    int n;
    cap = (CW_K[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW_K[k]) - 64'd1);
    lim = lim_in & cap;
    n = (n_in % 256 == 0) ? 1 : n_in % 256;
    total = 0; runs = 0; starts = 0; go_cyc = 0; to = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = (i < dly.size()) ? longint'(dly[i]) : 0;
      starts++;
      if (lim != 0 && (d == 0 || d > lim)) begin
        go_cyc += int'(lim);
        last = lim;
        to = 1'b1;
        break;
      end
      go_cyc += int'(d);
      last = (d > cap) ? cap : d;
      total = (total + last > cap) ? cap : total + last;
      runs++;
    end
  endfunction

  task automatic wait_idle(input string name);
    int c;
    for (c = 0; c < 4000 && busy_v != 3'b000; c++) @(negedge clk);
    chk({name, ".idle_budget"}, busy_v, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_seq(input string name, input int n, input longint unsigned lim);
    longint unsigned e_total;
    int e_runs, e_starts, e_go, phases;
    bit e_to;
    int s_go[3], s_rc[3], s_rp[3], s_rb[3], s_fin[3], s_ovl[3], s_gap[3], s_gb[3];
    for (int k = 0; k < 3; k++) begin
      s_go[k] = go_cnt[k]; s_rc[k] = rst_cyc[k]; s_rp[k] = rst_ph[k]; s_rb[k] = rst_bad[k];
      s_fin[k] = fin_cnt[k]; s_ovl[k] = ovl_cnt[k]; s_gap[k] = gaps[k]; s_gb[k] = gap_bad[k];
    end
    start = 1'b1;
    num_runs = 8'(n);
    cycle_limit = lim;
    @(negedge clk);
    // second start cycle lands while busy, with different inputs: must be ignored
    num_runs = 8'($urandom_range(0, 255));
    cycle_limit = 64'($urandom_range(1, 3));
    @(negedge clk);
    start = 1'b0;
    wait_idle(name);
    for (int k = 0; k < 3; k++) begin
      string t;
      t = $sformatf("%s[%0d]", name, k);
      predict(k, n, lim, exp_last[k], e_total, e_runs, e_starts, e_go, e_to);
      phases = (REARM_K[k] != 0) ? e_starts : 1;
      chk({t, ".last_cycles"}, get_last(k), exp_last[k]);
      chk({t, ".total_cycles"}, get_total(k), e_total);
      chk({t, ".runs_done"}, get_runs(k), e_runs);
      chk({t, ".timeout"}, to_v[k], e_to);
      chk({t, ".go_cycles"}, go_cnt[k] - s_go[k], e_go);
      chk({t, ".reset_phases"}, rst_ph[k] - s_rp[k], phases);
      chk({t, ".reset_cycles"}, rst_cyc[k] - s_rc[k], phases * RC_K[k]);
      chk({t, ".reset_len_bad"}, rst_bad[k] - s_rb[k], 0);
      chk({t, ".gaps"}, gaps[k] - s_gap[k], e_starts - 1);
      chk({t, ".gap_len_bad"}, gap_bad[k] - s_gb[k], 0);
      chk({t, ".finished_pulses"}, fin_cnt[k] - s_fin[k], 1);
      chk({t, ".go_reset_overlap"}, ovl_cnt[k] - s_ovl[k], 0);
    end
  endtask

  task automatic chk_reset_state(input string name);
    for (int k = 0; k < 3; k++) begin
      string t;
      t = $sformatf("%s[%0d]", name, k);
      chk({t, ".busy"}, busy_v[k], 0);
      chk({t, ".dut_go"}, go_v[k], 0);
      chk({t, ".dut_reset"}, rst_v[k], 0);
      chk({t, ".finished"}, fin_v[k], 0);
      chk({t, ".timeout"}, to_v[k], 0);
      chk({t, ".last_cycles"}, get_last(k), 0);
      chk({t, ".total_cycles"}, get_total(k), 0);
      chk({t, ".runs_done"}, get_runs(k), 0);
      exp_last[k] = 0;
    end
  endtask

  initial begin
    int n, c;
    longint unsigned lim;
    reset = 1'b1; start = 1'b0; num_runs = '0; cycle_limit = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    reset = 1'b0;
    @(negedge clk);

    dly = '{5};         run_seq("single_run", 1, 0);
    dly = '{2, 4, 6};   run_seq("three_runs", 3, 0);
    dly = '{0, 3};      run_seq("limit_timeout", 2, 10);
    dly = '{4};         run_seq("done_at_limit", 1, 4);
    dly = '{3, 3};      run_seq("two_runs", 2, 0);
    dly = '{2, 2};      run_seq("num_runs_zero", 0, 0);
    dly = '{20, 3};     run_seq("saturate", 2, 0);
    dly = '{1, 3, 5};   run_seq("timeout_mid_seq", 3, 3);
    dly = '{1};         run_seq("limit_one_done", 1, 1);

    // reset in the middle of a run
    dly = '{50};
    start = 1'b1; num_runs = 8'd1; cycle_limit = '0;
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < 100 && !go_v[0]; c++) @(negedge clk);
    chk("midrun.go_seen", go_v[0], 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("midrun_reset");
    reset = 1'b0;
    @(negedge clk);
    dly = '{7};         run_seq("after_reset", 1, 0);

    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(0, 4);
      lim = ($urandom_range(0, 1) == 0) ? 64'd0 : 64'($urandom_range(1, 12));
      dly.delete();
      for (int j = 0; j < 4; j++) begin
        if (lim != 0 && $urandom_range(0, 4) == 0) dly.push_back(0);
        else dly.push_back($urandom_range(1, 14));
      end
      run_seq($sformatf("rand%0d", i), n, lim);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
